// File: rtl/stream_cipher_pkg.sv
// Shared types and helpers for the stream_cipher subsystem.
//   cipher_state_t : top-level FSM encoding.
//   DefaultPoly    : default Galois feedback mask (32-bit LFSR).
//   lfsr_step      : one right-shift Galois step, returning the keystream bit and the next state.
//                    It operates on a MaxLfsrLen-wide container. Narrower LFSRs zero-extend
//                    their state and mask, and the upper bits then stay zero.
package stream_cipher_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, WARMUP, RUN} cipher_state_t;

  localparam int unsigned MaxLfsrLen  = 64;
  localparam logic [31:0] DefaultPoly = 32'h8020_0003;

  typedef struct packed {
    logic                  ks_bit;
    logic [MaxLfsrLen-1:0] state;
  } lfsr_step_t;

  function automatic lfsr_step_t lfsr_step(input logic [MaxLfsrLen-1:0] s,
                                           input logic [MaxLfsrLen-1:0] poly);
    lfsr_step_t r;
    r.ks_bit = s[0];
    r.state  = (s >> 1) ^ (s[0] ? poly : '0);
    return r;
  endfunction

endpackage

// File: rtl/lfsr_keystream.sv
// Combinational keystream word generator.
// It unrolls WIDTH Galois LFSR steps in a single cycle.
// Ports:
//   state_i      : current LFSR state.
//   ks_word_o    : WIDTH keystream bits. The first step's bit is placed in bit 0.
//   state_next_o : LFSR state after WIDTH steps.
module lfsr_keystream
  import stream_cipher_pkg::*;
#(
  parameter int unsigned         LFSR_LEN = 32,
  parameter logic [LFSR_LEN-1:0] POLY     = LFSR_LEN'(DefaultPoly),
  parameter int unsigned         WIDTH    = 8
) (
  input  logic [LFSR_LEN-1:0] state_i,
  output logic [WIDTH-1:0]    ks_word_o,
  output logic [LFSR_LEN-1:0] state_next_o
);

  localparam logic [MaxLfsrLen-1:0] PolyExt = MaxLfsrLen'(POLY);

  logic [MaxLfsrLen-1:0] walk;
  lfsr_step_t            step;

  always_comb begin
    walk      = '0;
    walk[LFSR_LEN-1:0] = state_i;
    step      = '0;
    ks_word_o = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      step         = lfsr_step(walk, PolyExt);
      ks_word_o[i] = step.ks_bit;
      walk         = step.state;
    end
    state_next_o = walk[LFSR_LEN-1:0];
  end

endmodule

// File: rtl/lfsr_stream_cipher.sv
// LFSR keystream cipher core.
// The output is the input word XOR the keystream, so the same core both encrypts and decrypts.
// It provides seed load, warm-up discard, valid/ready streaming and a registered output.
// Ports:
//   clk, rst                          : clock and asynchronous active-high reset.
//   seed_i, load_i                    : seed and single-cycle load strobe. load_i wins in any state.
//   in_valid_i, in_data_i, in_ready_o : input stream.
//   out_valid_o, out_data_o, out_ready_i : output stream, registered with 1-cycle latency.
//   busy_o                            : high in LOAD and WARMUP.
//   word_cnt_o                        : saturating count of accepted words. It is present only
//                                       when the macro CIPHER_CNT_EN is defined.
module lfsr_stream_cipher
  import stream_cipher_pkg::*;
#(
  parameter int unsigned         WIDTH         = 8,
  parameter int unsigned         LFSR_LEN      = 32,
  parameter logic [LFSR_LEN-1:0] POLY          = LFSR_LEN'(DefaultPoly),
  parameter int unsigned         WARMUP_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LFSR_LEN-1:0] seed_i,
  input  logic                load_i,
  input  logic                in_valid_i,
  input  logic [WIDTH-1:0]    in_data_i,
  output logic                in_ready_o,
  output logic                out_valid_o,
  output logic [WIDTH-1:0]    out_data_o,
  input  logic                out_ready_i,
`ifdef CIPHER_CNT_EN
  output logic [31:0]         word_cnt_o,
`endif
  output logic                busy_o
);

  localparam logic [7:0] WarmupLast = (WARMUP_CYCLES == 0) ? 8'd0 : 8'(WARMUP_CYCLES - 1);
  localparam logic [LFSR_LEN-1:0] LfsrOne = {{(LFSR_LEN-1){1'b0}}, 1'b1};

  cipher_state_t         state_q, state_d;
  logic [LFSR_LEN-1:0]   lfsr_q, lfsr_d, lfsr_adv;
  logic [WIDTH-1:0]      ks_word;
  logic [WIDTH-1:0]      out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [7:0]            warm_cnt_q, warm_cnt_d;
  logic                  accept;

  lfsr_keystream #(
    .LFSR_LEN (LFSR_LEN),
    .POLY     (POLY),
    .WIDTH    (WIDTH)
  ) u_keystream (
    .state_i      (lfsr_q),
    .ks_word_o    (ks_word),
    .state_next_o (lfsr_adv)
  );

  assign accept = in_valid_i && in_ready_o;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = LOAD;
    end else begin
      unique case (state_q)
        LOAD:    state_d = (WARMUP_CYCLES == 0) ? RUN : WARMUP;
        WARMUP:  if (warm_cnt_q == WarmupLast) state_d = RUN;
        default: ;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    in_ready_o = 1'b0;
    busy_o     = 1'b0;
    unique case (state_q)
      LOAD, WARMUP: busy_o     = 1'b1;
      RUN:          in_ready_o = !load_i && (!out_valid_q || out_ready_i);
      default: ;
    endcase
  end

  // Datapath: LFSR, warm-up counter and output register
  always_comb begin
    lfsr_d      = lfsr_q;
    warm_cnt_d  = warm_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load_i) begin
      // An all-zero seed would lock the LFSR at zero.
      lfsr_d      = (seed_i == '0) ? LfsrOne : seed_i;
      warm_cnt_d  = '0;
      out_valid_d = 1'b0;
    end else begin
      if (state_q == WARMUP) begin
        lfsr_d     = lfsr_adv;
        warm_cnt_d = warm_cnt_q + 8'd1;
      end
      if (accept) begin
        lfsr_d      = lfsr_adv;
        out_data_d  = in_data_i ^ ks_word;
        out_valid_d = 1'b1;
      end else if (out_ready_i) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q      <= LfsrOne;
      warm_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      lfsr_q      <= lfsr_d;
      warm_cnt_q  <= warm_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

`ifdef CIPHER_CNT_EN
  logic [31:0] word_cnt_q, word_cnt_d;

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (load_i || state_q == LOAD) begin
      word_cnt_d = '0;
    end else if (accept && word_cnt_q != 32'hFFFF_FFFF) begin
      word_cnt_d = word_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) word_cnt_q <= '0;
    else     word_cnt_q <= word_cnt_d;
  end

  assign word_cnt_o = word_cnt_q;
`endif

endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// Testbench for lfsr_stream_cipher.
// Instance a uses WARMUP 0, instance b uses WARMUP 4, and instance c uses WARMUP 0 as a decryptor
// chained after a.
module tb_lfsr_stream_cipher;

  localparam logic [31:0] Poly = 32'h8020_0003;

  logic clk, rst, chain;

  logic [31:0] a_seed, b_seed, c_seed;
  logic        a_load, b_load, c_load;
  logic        a_in_valid, b_in_valid, c_in_valid_mux;
  logic [7:0]  a_in_data, b_in_data;
  logic        a_in_ready, b_in_ready, c_in_ready;
  logic        a_out_valid, b_out_valid, c_out_valid;
  logic [7:0]  a_out_data, b_out_data, c_out_data;
  logic        a_out_ready, a_out_ready_mux, b_out_ready, c_out_ready;
  logic        a_busy, b_busy, c_busy;
`ifdef CIPHER_CNT_EN
  logic [31:0] a_cnt, b_cnt, c_cnt;
`endif

  int n_tests, n_fail;
  logic [7:0] ks_mdl [64];

  assign a_out_ready_mux = chain ? c_in_ready : a_out_ready;
  assign c_in_valid_mux  = chain ? a_out_valid : 1'b0;

  lfsr_stream_cipher #(.WIDTH(8), .LFSR_LEN(32), .WARMUP_CYCLES(0)) dut_a (
    .clk(clk), .rst(rst), .seed_i(a_seed), .load_i(a_load),
    .in_valid_i(a_in_valid), .in_data_i(a_in_data), .in_ready_o(a_in_ready),
    .out_valid_o(a_out_valid), .out_data_o(a_out_data), .out_ready_i(a_out_ready_mux),
`ifdef CIPHER_CNT_EN
    .word_cnt_o(a_cnt),
`endif
    .busy_o(a_busy)
  );

  lfsr_stream_cipher #(.WIDTH(8), .LFSR_LEN(32), .WARMUP_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .seed_i(b_seed), .load_i(b_load),
    .in_valid_i(b_in_valid), .in_data_i(b_in_data), .in_ready_o(b_in_ready),
    .out_valid_o(b_out_valid), .out_data_o(b_out_data), .out_ready_i(b_out_ready),
`ifdef CIPHER_CNT_EN
    .word_cnt_o(b_cnt),
`endif
    .busy_o(b_busy)
  );

  lfsr_stream_cipher #(.WIDTH(8), .LFSR_LEN(32), .WARMUP_CYCLES(0)) dut_c (
    .clk(clk), .rst(rst), .seed_i(c_seed), .load_i(c_load),
    .in_valid_i(c_in_valid_mux), .in_data_i(a_out_data), .in_ready_o(c_in_ready),
    .out_valid_o(c_out_valid), .out_data_o(c_out_data), .out_ready_i(c_out_ready),
`ifdef CIPHER_CNT_EN
    .word_cnt_o(c_cnt),
`endif
    .busy_o(c_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference keystream: bit stream from the Galois rule, packed LSB-first into bytes.
  task automatic gen_ks(input logic [31:0] seed);
    logic [31:0] s;
    s = (seed == 32'd0) ? 32'd1 : seed;
    for (int w = 0; w < 64; w++) begin
      for (int b = 0; b < 8; b++) begin
        ks_mdl[w][b] = s[0];
        s = (s >> 1) ^ (s[0] ? Poly : 32'd0);
      end
    end
  endtask

  typedef struct {
    logic [31:0] seed;
    logic [7:0]  din;
    logic [7:0]  exp;
  } kat_t;

  kat_t kat [6];

  initial begin
    logic [7:0]  pt [16];
    logic [7:0]  exp_q [$];
    logic [7:0]  pt_q [$];
    logic [7:0]  a_held, c_held, b_held;
    logic        a_stall, c_stall, b_stall;
    logic [31:0] rseed;
    int          busy_cnt, ready_seen, sent, got, ks_idx;

    n_tests = 0; n_fail = 0; chain = 1'b0;
    a_seed = '0; b_seed = '0; c_seed = '0;
    a_load = 0; b_load = 0; c_load = 0;
    a_in_valid = 0; b_in_valid = 0; a_in_data = '0; b_in_data = '0;
    a_out_ready = 1; b_out_ready = 1; c_out_ready = 1;

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    a_in_valid = 1'b1;
    #1;
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_data", a_out_data, 0);
    check("rst_in_ready_idle", a_in_ready, 0);
    check("rst_busy", a_busy, 0);
    check("rst_b_busy", b_busy, 0);
    tick();
    check("idle_no_accept", a_out_valid, 0);

    // Known-answer table on instance a
    rseed = $urandom;
    gen_ks(rseed);
    kat[0] = '{32'h1, 8'h00, 8'hDB};
    kat[1] = '{32'h1, 8'hFF, 8'h24};
    kat[2] = '{32'h0, 8'h00, 8'hDB};
    kat[3] = '{32'h0, 8'hFF, 8'h24};
    kat[4] = '{32'h1, 8'hA5, 8'h7E};
    kat[5] = '{rseed, 8'h5A, 8'h5A ^ ks_mdl[0]};
    for (int k = 0; k < 6; k++) begin
      a_seed = kat[k].seed; a_load = 1'b1; a_in_valid = 1'b1; a_in_data = kat[k].din;
      #1;
      check("kat_ready_during_load", a_in_ready, 0);
      tick();
      a_load = 1'b0; a_in_valid = 1'b0;
      check("kat_busy_load", a_busy, 1);
      check("kat_no_out_on_load", a_out_valid, 0);
      tick();
      check("kat_busy_run", a_busy, 0);
      a_in_valid = 1'b1;
      #1;
      check("kat_ready_run", a_in_ready, 1);
      tick();
      a_in_valid = 1'b0;
      check("kat_out_valid", a_out_valid, 1);
      check("kat_out_data", a_out_data, kat[k].exp);
      tick();
      check("kat_drained", a_out_valid, 0);
    end

    // Warm-up on instance b
    gen_ks(32'h1);
    b_seed = 32'h1; b_load = 1'b1; b_in_valid = 1'b1; b_in_data = 8'h3C; b_out_ready = 1'b0;
    #1;
    check("wu_ready_load", b_in_ready, 0);
    tick();
    b_load = 1'b0;
    busy_cnt = 0; ready_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (!b_busy) break;
      busy_cnt++;
      if (b_in_ready) ready_seen = 1;
      tick();
    end
    check("wu_busy_cycles", busy_cnt, 5);
    check("wu_ready_while_busy", ready_seen, 0);
    check("wu_no_early_out", b_out_valid, 0);
    check("wu_ready_run", b_in_ready, 1);
    tick();
    b_in_valid = 1'b0;
    check("wu_first_word", b_out_data, 8'h3C ^ ks_mdl[4]);
    b_out_ready = 1'b1;
    tick();

    // Random stream with backpressure on b against the model
    ks_idx = 5; sent = 0; got = 0; b_stall = 0; b_held = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 400 && got < 24; cyc++) begin
      b_in_valid  = (sent < 24) && ($urandom_range(0, 2) != 0);
      b_in_data   = 8'($urandom);
      b_out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rnd_valid", b_out_valid, (exp_q.size() != 0));
      if (b_stall) check("rnd_hold", b_out_data, b_held);
      if (b_out_valid && b_out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rnd_extra: got %0h expected no word", b_out_data);
        end else begin
          check("rnd_data", b_out_data, exp_q.pop_front());
        end
        got++;
      end
      if (b_in_valid && b_in_ready) begin
        exp_q.push_back(b_in_data ^ ks_mdl[ks_idx]);
        ks_idx++; sent++;
      end
      b_stall = b_out_valid && !b_out_ready;
      b_held  = b_out_data;
      @(posedge clk); #1;
    end
    check("rnd_count", got, 24);
    b_in_valid = 1'b0;

    // Encrypt through a, decrypt through c, with random backpressure
    for (int i = 0; i < 16; i++) pt[i] = 8'($urandom);
    chain = 1'b1;
    a_seed = 32'h0BAD_C0DE; c_seed = 32'h0BAD_C0DE; a_load = 1; c_load = 1;
    tick();
    a_load = 0; c_load = 0;
    tick();
    sent = 0; got = 0; a_stall = 0; c_stall = 0; a_held = '0; c_held = '0;
    pt_q.delete();
    for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
      a_in_valid  = (sent < 16) && ($urandom_range(0, 3) != 0);
      a_in_data   = pt[sent % 16];
      c_out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (a_stall) begin
        check("chain_a_hold_valid", a_out_valid, 1);
        check("chain_a_hold_data", a_out_data, a_held);
      end
      if (c_stall) check("chain_c_hold_data", c_out_data, c_held);
      if (c_out_valid && c_out_ready) begin
        if (pt_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL chain_extra: got %0h expected no word", c_out_data);
        end else begin
          check("chain_plain", c_out_data, pt_q.pop_front());
        end
        got++;
      end
      if (a_in_valid && a_in_ready) begin
        pt_q.push_back(a_in_data);
        sent++;
      end
      a_stall = a_out_valid && !c_in_ready; a_held = a_out_data;
      c_stall = c_out_valid && !c_out_ready; c_held = c_out_data;
      @(posedge clk); #1;
    end
    check("chain_count", got, 16);
    a_in_valid = 1'b0;
    c_out_ready = 1'b1;
    chain = 1'b0;
    tick();

    // Mid-stream load with a stalled output word
    gen_ks(32'h1234_5678);
    a_seed = 32'h1234_5678; a_load = 1;
    tick();
    a_load = 0;
    tick();
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 8'h11;
    tick();
    a_in_valid = 1'b0;
    check("mid_first", a_out_data, 8'h11 ^ ks_mdl[0]);
    tick();
    check("mid_stall_valid", a_out_valid, 1);
    check("mid_stall_data", a_out_data, 8'h11 ^ ks_mdl[0]);
    gen_ks(32'hCAFE_F00D);
    a_seed = 32'hCAFE_F00D; a_load = 1'b1; a_in_valid = 1'b1; a_in_data = 8'h77;
    #1;
    check("mid_ready_on_load", a_in_ready, 0);
    tick();
    a_load = 1'b0; a_in_valid = 1'b0;
    check("mid_valid_dropped", a_out_valid, 0);
    check("mid_busy", a_busy, 1);
    tick();
    check("mid_busy_done", a_busy, 0);
`ifdef CIPHER_CNT_EN
    check("mid_cnt_cleared", a_cnt, 0);
`endif
    a_in_valid = 1'b1; a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    check("mid_restart", a_out_data, 8'h77 ^ ks_mdl[0]);
`ifdef CIPHER_CNT_EN
    check("mid_cnt_one", a_cnt, 1);
`endif

    // Asynchronous reset between clock edges with a word pending
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 8'h42;
    tick();
    a_in_valid = 1'b0;
    check("arst_pre_valid", a_out_valid, 1);
    #3 rst = 1'b1;
    #1;
    check("arst_out_valid", a_out_valid, 0);
    check("arst_out_data", a_out_data, 0);
    check("arst_in_ready", a_in_ready, 0);
    check("arst_busy", a_busy, 0);
    tick();
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_stream_cipher.md
Name: lfsr_stream_cipher

Overview:
Parametrised keystream cipher core for the stream_cipher subsystem, and the generalised successor to the single-configuration source block.
- A Galois LFSR of LFSR_LEN bits, with a configurable feedback polynomial, produces WIDTH keystream bits per accepted word.
- Each keystream word is XORed with the input data word, so the same block both encrypts and decrypts.
- Adds seed load, configurable warm-up discard, and valid/ready streaming with a registered output.

Parameters:
- WIDTH, 8: data and keystream word width in bits, 1..32.
- LFSR_LEN, 32: LFSR state width, 8..64.
- POLY, 32'h8020_0003: Galois feedback mask, LFSR_LEN bits wide.
- WARMUP_CYCLES, 4: words of keystream discarded after a seed load, 0..255.

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: asynchronous active-high reset.
- seed_i, in, LFSR_LEN: key/IV seed, sampled when load_i is high.
- load_i, in, 1: single-cycle seed load strobe.
- in_valid_i, in, 1: input word valid.
- in_data_i, in, WIDTH: plaintext or ciphertext word.
- in_ready_o, out, 1: block can accept an input word this cycle.
- out_valid_o, out, 1: output word valid.
- out_data_o, out, WIDTH: input word XOR keystream word.
- out_ready_i, in, 1: downstream accepts the output word.
- busy_o, out, 1: high while a seed load or warm-up is in progress.

Behaviour:
- Reset, asynchronous on rst high:
  - state IDLE, LFSR = 1.
  - out_valid_o = 0, out_data_o = 0, in_ready_o = 0, busy_o = 0.
- LFSR single step (Galois, right shift):
  - ks_bit = s[0].
  - s = (s >> 1) ^ (s[0] ? POLY : 0).
- Keystream word:
  - WIDTH successive steps, unrolled combinationally in one cycle.
  - The first step's bit goes to bit 0 of the word.
- FSM states IDLE, LOAD, WARMUP, RUN:
  - IDLE: in_ready_o = 0. load_i -> LOAD.
  - LOAD: one cycle. LFSR <= seed_i, except an all-zero seed_i loads 1 (lock-up avoidance). Then -> WARMUP, or -> RUN if WARMUP_CYCLES == 0.
  - WARMUP: each cycle advances the LFSR by one word (WIDTH steps) and increments the warm-up counter. After WARMUP_CYCLES cycles -> RUN.
  - RUN: in_ready_o = !out_valid_o || out_ready_i.
- Accepting a word in RUN (in_valid_i && in_ready_o):
  - out_data_o <= in_data_i ^ ks_word.
  - out_valid_o <= 1.
  - LFSR advances WIDTH steps.
  - Latency is 1 cycle. Full throughput when out_ready_i is held high.
- Output register:
  - Holds out_data_o stable while out_valid_o && !out_ready_i.
  - Clears out_valid_o on out_ready_i when no new word is accepted in the same cycle.
  - Simultaneous output drain and input accept in the same cycle: the register is replaced, out_valid_o stays 1.
- The LFSR advances only on an accepted word or a WARMUP cycle; stall cycles leave it unchanged.
- busy_o = 1 in LOAD and WARMUP.
- load_i has priority in any state, including mid-stream:
  - Next state is LOAD and out_valid_o <= 0; a pending output word is dropped.
  - The input word presented in that cycle is not accepted (in_ready_o = 0 while busy_o = 1 or a load is pending).
- load_i asserted during WARMUP restarts LOAD and clears the warm-up counter.

Optional Feature:
- Macro: CIPHER_CNT_EN.
- Defined:
  - Adds output port word_cnt_o, 32 bits: count of words accepted since the last load or reset.
  - Cleared in LOAD and on reset; saturates at 32'hFFFF_FFFF; increments on in_valid_i && in_ready_o.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package stream_cipher_pkg:
  - typedef enum logic [1:0] cipher_state_t {IDLE, LOAD, WARMUP, RUN}.
  - Default POLY constant.
  - Function lfsr_step, returning next state and output bit.
- Sub-module lfsr_keystream (parameters LFSR_LEN, POLY, WIDTH):
  - Combinational word generator: current state -> ks_word, next state.
  - Instantiated once; the FSM and handshake stay in the top level.

Test Plan:
- Reset: hold rst high 2 cycles, then release -> out_valid_o = 0, in_ready_o = 0, busy_o = 0, state IDLE.
- Known answer (WIDTH = 8, WARMUP_CYCLES = 0, POLY default): load seed 32'h1, send 8'h00 -> out_data_o = 8'hDB one cycle after acceptance, LFSR = 32'hDB36C002.
  - Reload seed 32'h1 and send 8'hFF -> out_data_o = 8'h24.
- Zero seed: load 32'h0 -> output identical to the seed 32'h1 case (8'hDB for input 8'h00).
- Warm-up (WARMUP_CYCLES = 4, seed 32'h1):
  - busy_o is high for exactly 5 cycles (LOAD + 4 WARMUP) and in_ready_o is low throughout.
  - The first output equals the model's 5th keystream word.
- Backpressure: stream 16 words while toggling out_ready_i at random -> no word lost or duplicated, out_data_o stable while stalled, and decrypting through a second instance with the same seed recovers the plaintext.
- Mid-stream load: assert load_i while out_valid_o = 1 and out_ready_i = 0 -> out_valid_o falls next cycle, busy_o rises, and the new stream restarts from the new seed.
  - With CIPHER_CNT_EN defined: word_cnt_o reads 0 after the load.
